hamming_decoder: RTL and testbench
==================================

Name: hamming_decoder

Overview:
- Serial SECDED decoder for the extended Hamming(16,11) block produced by the team's serial encoder. Block bit index k = 0..15 arrives in order; parity sits at positions 0 (overall), 1, 2, 4 and 8.
- Collects one 16-bit block, computes the syndrome and overall parity, and corrects any single-bit error.
- Flags double errors and serialises the 11 data bits back out, with a per-bit strobe on clkout.
- Sits at the receive end of the link, directly after the channel.

Parameters:
- NBITS, 16, block length; fixed by the code; only 16 is supported.
- NDATA, 11, data bits per block; fixed; only 11 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- datain  input  1  serial code bit; sampled when validin=1.
- validin  input  1  qualifies datain for the current cycle.
- dataout  output  1  serial decoded data bit.
- clkout  output  1  data strobe; dataout is valid when clkout=1.
- err_single  output  1  last block had a corrected single error; held until the next block's load.
- err_double  output  1  last block had an uncorrectable double error; held until the next block's load.
- blkdone  output  1  one-cycle pulse when a decoded block is loaded.

Behaviour:
- Reset (rst_n=0, async): clear bit counter, input shift memory and output buffer. dataout=0, clkout=0, err_single=0, err_double=0, blkdone=0. Output state is IDLE.
- Input side:
  - 4-bit counter cnt.
  - On each edge with validin=1, store datain into mem[cnt] and increment cnt.
  - validin=0 holds cnt and mem, so gaps are allowed anywhere in a block.
  - When the bit at cnt=15 is stored, cnt wraps to 0 and the load flag is set for the next cycle.
- Decode, computed combinationally from the full mem in the cycle after the 16th bit:
  - syn[3:0] = XOR of indices i (1..15) where mem[i]=1.
  - par = XOR of mem[0..15].
  - syn=0, par=0: no error.
  - par=1: single error at position syn (syn=0 means bit 0). Invert that bit; err_single=1.
  - syn!=0, par=0: double error. err_double=1; data is forwarded uncorrected.
- Load edge, exactly one cycle after the edge that captured bit 15:
  - Write corrected data bits from positions 3,5,6,7,9,10,11,12,13,14,15, in that order, into obuf[0..10].
  - Update err_single and err_double; pulse blkdone=1 for one cycle.
  - Output FSM: IDLE -> SEND with ocnt=0.
- Output FSM:
  - SEND: dataout=obuf[ocnt], clkout=1. ocnt increments each cycle; after ocnt=10, return to IDLE with clkout=0 and dataout=0.
  - Output is registered. The first data bit appears in the cycle after the load edge: 2 cycles after bit 15 is sampled. It lasts 11 cycles.
- Overlap:
  - The input side accepts the next block while SEND is running. The next load cannot occur before 16 cycles after the previous one, so SEND always completes before the next load.
  - If a load and the final SEND cycle coincide, the load wins and SEND restarts at ocnt=0.
- Reset mid-block or mid-SEND discards the partial block and all pending output immediately.

Test Plan:
- Clean block 1111000000000000 (index 0 first), validin=1 continuously -> blkdone pulse, then 11 strobes with dataout 1,0,0,0,0,0,0,0,0,0,0; err_single=0, err_double=0.
- Same block with bit 9 flipped (1111000001000000) -> syn=9, par=1; output identical to the clean case; err_single=1.
- Bit 0 flipped (0111000000000000) -> syn=0, par=1; output 1 followed by ten 0s; err_single=1, err_double=0.
- Bits 3 and 5 flipped (1110010000000000) -> syn=6, par=0; err_double=1; raw data out 0,1,0,0,0,0,0,0,0,0,0.
- Clean block sent with validin=0 for 3 cycles after bit 7 -> identical result, delayed by 3 cycles; then two clean blocks back-to-back -> two full 11-bit bursts and two blkdone pulses 16 cycles apart.
- rst_n pulsed low after bit 10 of a block, then a full clean block -> no output from the aborted block; the clean block decodes correctly with flags 0.

Source files
------------

// File: rtl/hamming_decoder.sv
// Serial SECDED decoder for extended Hamming(16,11): collects a 16-bit block,
// corrects single errors, flags double errors and streams the 11 data bits out.
module hamming_decoder #(
  parameter int NBITS = 16,
  parameter int NDATA = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic datain,
  input  logic validin,
  output logic dataout,
  output logic clkout,
  output logic err_single,
  output logic err_double,
  output logic blkdone
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_n;
  logic [3:0]         cnt;
  logic [3:0]         ocnt, ocnt_n;
  logic [NBITS-1:0]   mem;
  logic [NDATA-1:0]   obuf;
  logic               ld;
  logic               dout_n, cout_n;

  logic [3:0]         syn;
  logic               par;
  logic [NBITS-1:0]   fix, cor;
  logic [NDATA-1:0]   dbits;

  // Input side: bit capture, counter and load flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mem <= '0;
      ld  <= 1'b0;
    end else begin
      ld <= validin && (cnt == 4'd15);
      if (validin) begin
        mem[cnt] <= datain;
        cnt      <= cnt + 4'd1;
      end
    end
  end

  always_comb begin
    syn = '0;
    for (int unsigned i = 1; i < 16; i++) begin
      if (mem[i]) syn = syn ^ 4'(i);
    end
    par = ^mem;
    fix = '0;
    if (par) fix[syn] = 1'b1;
    cor   = mem ^ fix;
    dbits = {cor[15], cor[14], cor[13], cor[12], cor[11], cor[10],
             cor[9], cor[7], cor[6], cor[5], cor[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf       <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
      blkdone    <= 1'b0;
    end else begin
      blkdone <= ld;
      if (ld) begin
        obuf       <= dbits;
        err_single <= par;
        err_double <= (syn != 4'd0) && !par;
      end
    end
  end

  // Output FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ocnt  <= '0;
    end else begin
      state <= state_n;
      ocnt  <= ocnt_n;
    end
  end

  // A load always restarts the burst, even on the last SEND cycle
  always_comb begin
    state_n = state;
    ocnt_n  = ocnt;
    if (ld) begin
      state_n = SEND;
      ocnt_n  = '0;
    end else if (state == SEND) begin
      if (ocnt == 4'(NDATA - 1)) begin
        state_n = IDLE;
        ocnt_n  = '0;
      end else begin
        ocnt_n = ocnt + 4'd1;
      end
    end
  end

  always_comb begin
    dout_n = 1'b0;
    cout_n = 1'b0;
    if (state == SEND) begin
      dout_n = obuf[ocnt];
      cout_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout <= 1'b0;
      clkout  <= 1'b0;
    end else begin
      dataout <= dout_n;
      clkout  <= cout_n;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: hand-decoded blocks, gaps, back-to-back and reset abort.
module tb_hamming_decoder;

  logic clk = 1'b0;
  logic rst_n, datain, validin;
  logic dataout, clkout, err_single, err_double, blkdone;

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;
  int last15;

  int   bq[$];
  int   sq[$];
  logic obits[$];

  hamming_decoder #(.NBITS(16), .NDATA(11)) dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .validin(validin),
    .dataout(dataout), .clkout(clkout), .err_single(err_single),
    .err_double(err_double), .blkdone(blkdone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (blkdone) bq.push_back(cyc);
    if (clkout) begin
      sq.push_back(cyc);
      obits.push_back(dataout);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    bq.delete();
    sq.delete();
    obits.delete();
  endtask

  task automatic send_blk(input logic [0:15] b, input int gapat, input int nb);
    for (int k = 0; k < nb; k++) begin
      datain  = b[k];
      validin = 1'b1;
      @(posedge clk); #1;
      last15 = cyc;
      if (k == gapat) begin
        validin = 1'b0;
        datain  = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
    end
    validin = 1'b0;
    datain  = 1'b0;
  endtask

  task automatic burst_check(input string tag, input int first, input int base,
                             input logic [10:0] exp);
    logic [10:0] got = '0;
    for (int i = 0; i < 11; i++) got = {got[9:0], obits[base + i]};
    chk({tag, ".latency"}, sq[base] - first, 2);
    chk({tag, ".contig"}, sq[base + 10] - sq[base], 10);
    chk({tag, ".data"}, got, exp);
  endtask

  task automatic run_case(input string tag, input logic [0:15] b, input int gapat,
                          input logic [10:0] exp, input logic es, input logic ed);
    clear_mon();
    send_blk(b, gapat, 16);
    repeat (16) @(posedge clk);
    #1;
    chk({tag, ".blkdone_cnt"}, bq.size(), 1);
    chk({tag, ".strobe_cnt"}, sq.size(), 11);
    if (bq.size() == 1) chk({tag, ".blkdone_at"}, bq[0] - last15, 1);
    if (sq.size() == 11) burst_check(tag, last15, 0, exp);
    chk({tag, ".err_single"}, err_single, es);
    chk({tag, ".err_double"}, err_double, ed);
  endtask

  initial begin
    int s1;
    rst_n   = 1'b0;
    datain  = 1'b0;
    validin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outs", {dataout, clkout, err_single, err_double, blkdone}, 5'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_case("clean", 16'b1111000000000000, -1, 11'b10000000000, 1'b0, 1'b0);
    run_case("bit9",  16'b1111000001000000, -1, 11'b10000000000, 1'b1, 1'b0);
    run_case("bit0",  16'b0111000000000000, -1, 11'b10000000000, 1'b1, 1'b0);
    run_case("dbl35", 16'b1110010000000000, -1, 11'b01000000000, 1'b0, 1'b1);
    run_case("gap",   16'b1111000000000000,  7, 11'b10000000000, 1'b0, 1'b0);

    clear_mon();
    send_blk(16'b1111000000000000, -1, 16);
    s1 = last15;
    send_blk(16'b1111000000000000, -1, 16);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b.blkdone_cnt", bq.size(), 2);
    chk("b2b.strobe_cnt", sq.size(), 22);
    if (bq.size() == 2) chk("b2b.blk_spacing", bq[1] - bq[0], 16);
    if (sq.size() == 22) begin
      burst_check("b2b.first", s1, 0, 11'b10000000000);
      burst_check("b2b.second", last15, 11, 11'b10000000000);
    end

    clear_mon();
    send_blk(16'b1111000000000000, -1, 11);
    rst_n = 1'b0;
    #1;
    chk("abort.outs", {dataout, clkout, err_single, err_double, blkdone}, 5'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_case("after_rst", 16'b1111000000000000, -1, 11'b10000000000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
